pipeline_hazard_ctrl: RTL and testbench

Central stall/flush/forwarding controller for the 5-stage pipelined CPU (IF, DEC, EXE, MEM, WB). It tracks the destination registers of in-flight instructions and detects RAW hazards against the instruction in DEC. It drives the four pipeline-buffer enables and the PC write enable, squashes wrong-path instructions on an EXE-stage redirect, and supplies registered forwarding selects to the EXE operand muxes. It replaces the constant `isStalled = 0` / always-enabled buffer wiring in the CPU top level.

---
 rtl/pipeline_pkg.sv | 33 +++
 rtl/pipeline_hazard_ctrl_if.sv | 45 ++++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

   localparam int REG_INDEX_BIT_WIDTH_DEF = 4;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EXMEM   = 2'b01;
   localparam logic [1:0] FWD_MEMWB   = 2'b10;

   typedef struct packed {
      logic                               valid;
      logic [REG_INDEX_BIT_WIDTH_DEF-1:0] dst;
      logic                               wr;
      logic                               ld;
   } trk_entry_t;

   typedef enum logic [1:0] {
      MODE_NORMAL,
      MODE_STALL,
      MODE_REDIRECT,
      MODE_FREEZE
   } ctrl_mode_e;

   function automatic logic src_match(trk_entry_t e, logic used,
                                      logic [REG_INDEX_BIT_WIDTH_DEF-1:0] src);
      return e.valid & e.wr & used & (e.dst == src);
   endfunction

   function automatic logic [1:0] fwd_sel(logic ex_hit, logic mem_hit);
      return ex_hit ? FWD_EXMEM : (mem_hit ? FWD_MEMWB : FWD_REGFILE);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// DEC-stage request and pipeline control bundle between the CPU and the hazard controller.
interface pipeline_hazard_ctrl_if #(
   parameter int REG_INDEX_BIT_WIDTH = pipeline_pkg::REG_INDEX_BIT_WIDTH_DEF,
   parameter int CNT_BITS            = 16
);
   // dec_valid qualifies every dec_* field in the same cycle; the DEC instruction is
   // accepted into EXE on a rising edge only when decExeEn=1 and dec_exe_bubble=0.
   logic                           dec_valid;
   logic [REG_INDEX_BIT_WIDTH-1:0] dec_src1;
   logic [REG_INDEX_BIT_WIDTH-1:0] dec_src2;
   logic                           dec_src1_used;
   logic                           dec_src2_used;
   logic [REG_INDEX_BIT_WIDTH-1:0] dec_dst;
   logic                           dec_reg_wrt;
   logic                           dec_is_load;
   logic                           exe_redirect;
   logic                           mem_wait;

   logic                           pc_wrt_en;
   logic                           ifDecEn;
   logic                           decExeEn;
   logic                           exeMemEn;
   logic                           memWbEn;
   logic                           if_dec_flush;
   logic                           dec_exe_bubble;
   logic [1:0]                     fwd_a_sel;
   logic [1:0]                     fwd_b_sel;
   logic                           isStalled;
   logic [CNT_BITS-1:0]            stall_count;
   logic [CNT_BITS-1:0]            flush_count;

   modport master (
      output dec_valid, dec_src1, dec_src2, dec_src1_used, dec_src2_used,
             dec_dst, dec_reg_wrt, dec_is_load, exe_redirect, mem_wait,
      input  pc_wrt_en, ifDecEn, decExeEn, exeMemEn, memWbEn, if_dec_flush,
             dec_exe_bubble, fwd_a_sel, fwd_b_sel, isStalled, stall_count, flush_count
   );

   modport slave (
      input  dec_valid, dec_src1, dec_src2, dec_src1_used, dec_src2_used,
             dec_dst, dec_reg_wrt, dec_is_load, exe_redirect, mem_wait,
      output pc_wrt_en, ifDecEn, decExeEn, exeMemEn, memWbEn, if_dec_flush,
             dec_exe_bubble, fwd_a_sel, fwd_b_sel, isStalled, stall_count, flush_count
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);
   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count_o = count_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline (IF, DEC, EXE, MEM, WB).
// Define FORWARDING_EN to use forwarding selects; otherwise any RAW match in EX/MEM stalls.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int REG_INDEX_BIT_WIDTH = REG_INDEX_BIT_WIDTH_DEF,
   parameter int CNT_BITS            = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   pipeline_hazard_ctrl_if.slave hz
);
   trk_entry_t          ex_q, ex_d, mem_q, mem_d;
   ctrl_mode_e          mode;
   logic                ex_hit1, ex_hit2, mem_hit1, mem_hit2, hazard;
   logic [CNT_BITS-1:0] stall_cnt, flush_cnt;

   assign ex_hit1  = src_match(ex_q,  hz.dec_src1_used, hz.dec_src1);
   assign ex_hit2  = src_match(ex_q,  hz.dec_src2_used, hz.dec_src2);
   assign mem_hit1 = src_match(mem_q, hz.dec_src1_used, hz.dec_src1);
   assign mem_hit2 = src_match(mem_q, hz.dec_src2_used, hz.dec_src2);

`ifdef FORWARDING_EN
   assign hazard = hz.dec_valid & ex_q.ld & (ex_hit1 | ex_hit2);
`else
   assign hazard = hz.dec_valid & (ex_hit1 | ex_hit2 | mem_hit1 | mem_hit2);
`endif

   always_comb begin
      mode = MODE_NORMAL;
      if (hz.mem_wait)          mode = MODE_FREEZE;
      else if (hz.exe_redirect) mode = MODE_REDIRECT;
      else if (hazard)          mode = MODE_STALL;
   end

   always_comb begin
      hz.pc_wrt_en      = 1'b1;
      hz.ifDecEn        = 1'b1;
      hz.decExeEn       = 1'b1;
      hz.exeMemEn       = 1'b1;
      hz.memWbEn        = 1'b1;
      hz.if_dec_flush   = 1'b0;
      hz.dec_exe_bubble = 1'b0;
      hz.isStalled      = 1'b0;
      ex_d  = '{valid: hz.dec_valid, dst: hz.dec_dst, wr: hz.dec_reg_wrt, ld: hz.dec_is_load};
      mem_d = ex_q;
      case (mode)
         MODE_FREEZE: begin
            hz.pc_wrt_en = 1'b0;
            hz.ifDecEn   = 1'b0;
            hz.decExeEn  = 1'b0;
            hz.exeMemEn  = 1'b0;
            hz.memWbEn   = 1'b0;
            ex_d         = ex_q;
            mem_d        = mem_q;
         end
         // Squashing DEC also discards any hazard it had.
         MODE_REDIRECT: begin
            hz.if_dec_flush   = 1'b1;
            hz.dec_exe_bubble = 1'b1;
            ex_d              = '0;
         end
         MODE_STALL: begin
            hz.pc_wrt_en      = 1'b0;
            hz.ifDecEn        = 1'b0;
            hz.dec_exe_bubble = 1'b1;
            hz.isStalled      = 1'b1;
            ex_d              = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_q  <= '0;
         mem_q <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
      end
   end

`ifdef FORWARDING_EN
   logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

   // Selects load with DEC_EXE: fresh on accept, cleared on bubble/flush, held on freeze.
   always_comb begin
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
      if (mode == MODE_NORMAL) begin
         fwd_a_d = fwd_sel(ex_hit1, mem_hit1);
         fwd_b_d = fwd_sel(ex_hit2, mem_hit2);
      end else if (mode != MODE_FREEZE) begin
         fwd_a_d = FWD_REGFILE;
         fwd_b_d = FWD_REGFILE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fwd_a_q <= FWD_REGFILE;
         fwd_b_q <= FWD_REGFILE;
      end else begin
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end

   assign hz.fwd_a_sel = fwd_a_q;
   assign hz.fwd_b_sel = fwd_b_q;
`else
   assign hz.fwd_a_sel = FWD_REGFILE;
   assign hz.fwd_b_sel = FWD_REGFILE;
`endif

   sat_counter #(.WIDTH(CNT_BITS)) u_stall_cnt (
      .clk     (clk),
      .rst_n   (reset),
      .inc_i   (mode == MODE_STALL),
      .count_o (stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_BITS)) u_flush_cnt (
      .clk     (clk),
      .rst_n   (reset),
      .inc_i   (mode == MODE_REDIRECT),
      .count_o (flush_cnt)
   );

   assign hz.stall_count = stall_cnt;
   assign hz.flush_count = flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl; works with or without FORWARDING_EN defined.
module tb_pipeline_hazard_ctrl;
   localparam int RW    = 4;
   localparam int CW    = 16;
   localparam int SW    = 8;
   localparam int EXP_W = 52;
`ifdef FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.REG_INDEX_BIT_WIDTH(RW), .CNT_BITS(CW)) hz ();
   pipeline_hazard_ctrl_if #(.REG_INDEX_BIT_WIDTH(RW), .CNT_BITS(SW)) hs ();

   pipeline_hazard_ctrl #(.REG_INDEX_BIT_WIDTH(RW), .CNT_BITS(CW)) dut (
      .clk(clk), .reset(reset), .hz(hz));
   // Narrow-counter twin sees identical stimulus so saturation is reached quickly.
   pipeline_hazard_ctrl #(.REG_INDEX_BIT_WIDTH(RW), .CNT_BITS(SW)) dut_sat (
      .clk(clk), .reset(reset), .hz(hs));

   assign hs.dec_valid     = hz.dec_valid;
   assign hs.dec_src1      = hz.dec_src1;
   assign hs.dec_src2      = hz.dec_src2;
   assign hs.dec_src1_used = hz.dec_src1_used;
   assign hs.dec_src2_used = hz.dec_src2_used;
   assign hs.dec_dst       = hz.dec_dst;
   assign hs.dec_reg_wrt   = hz.dec_reg_wrt;
   assign hs.dec_is_load   = hz.dec_is_load;
   assign hs.exe_redirect  = hz.exe_redirect;
   assign hs.mem_wait      = hz.mem_wait;

   // ---------------- reference model ----------------
   typedef struct { bit valid; int dst; bit wr; bit ld; } instr_t;
   instr_t hist[$];            // hist[0]: instruction in EXE, hist[1]: in MEM
   int m_fwd_a = 0, m_fwd_b = 0, n_stall = 0, n_flush = 0;
   logic [EXP_W-1:0] exp_q[$];
   int n_cmp = 0, n_bad = 0;

   function automatic instr_t mk(bit v, int d, bit w, bit l);
      instr_t x;
      x.valid = v; x.dst = d; x.wr = w; x.ld = l;
      return x;
   endfunction

   // Distance to the nearest in-flight writer of s: 1 = EXE, 2 = MEM, 0 = none.
   function automatic int prod_dist(int s, bit used);
      int d = 0;
      if (used)
         for (int k = hist.size() - 1; k >= 0; k--)
            if (hist[k].valid && hist[k].wr && hist[k].dst == s) d = k + 1;
      return d;
   endfunction

   function automatic int sat(int n, int w);
      return (n >= (1 << w)) ? (1 << w) - 1 : n;
   endfunction

   function automatic void model_reset();
      hist.delete();
      hist.push_back(mk(0, 0, 0, 0));
      hist.push_back(mk(0, 0, 0, 0));
      m_fwd_a = 0; m_fwd_b = 0; n_stall = 0; n_flush = 0;
   endfunction

   // ---------------- driver ----------------
   task automatic go(input bit rn, input bit redir, input bit mw,
                     input bit v, input int dst, input bit wr, input bit ld,
                     input int s1, input bit u1, input int s2, input bit u2,
                     output bit accepted);
      int d1, d2;
      bit hazard;
      logic [7:0] ctl;
      logic [1:0] ea, eb;
      reset            = rn;
      hz.dec_valid     = v;
      hz.dec_dst       = RW'(dst);
      hz.dec_reg_wrt   = wr;
      hz.dec_is_load   = ld;
      hz.dec_src1      = RW'(s1);
      hz.dec_src1_used = u1;
      hz.dec_src2      = RW'(s2);
      hz.dec_src2_used = u2;
      hz.exe_redirect  = redir;
      hz.mem_wait      = mw;
      if (!rn) model_reset();
      d1 = prod_dist(s1, u1);
      d2 = prod_dist(s2, u2);
      if (FWD) hazard = v && hist[0].ld && (d1 == 1 || d2 == 1);
      else     hazard = v && (d1 != 0 || d2 != 0);
      // {pc, ifdec, decexe, exemem, memwb, flush, bubble, stalled}
      if (mw)          ctl = 8'b00000_000;
      else if (redir)  ctl = 8'b11111_110;
      else if (hazard) ctl = 8'b00111_011;
      else             ctl = 8'b11111_000;
      ea = m_fwd_a[1:0];
      eb = m_fwd_b[1:0];
      exp_q.push_back({ctl, ea, eb, 16'(sat(n_stall, CW)), 16'(sat(n_flush, CW)),
                       8'(sat(n_stall, SW))});
      accepted = 1'b0;
      if (rn && !mw) begin
         if (redir || hazard) begin
            hist.push_front(mk(0, 0, 0, 0));
            m_fwd_a = 0; m_fwd_b = 0;
            if (redir) n_flush++;
            else       n_stall++;
         end else begin
            hist.push_front(mk(v, dst, wr, ld));
            m_fwd_a = FWD ? d1 : 0;
            m_fwd_b = FWD ? d2 : 0;
            accepted = 1'b1;
         end
         void'(hist.pop_back());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      bit a;
      go(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
   endtask

   // Holds the DEC instruction until the model says EXE accepted it.
   task automatic issue(input int dst, input bit wr, input bit ld,
                        input int s1, input bit u1, input int s2, input bit u2);
      bit a = 1'b0;
      for (int k = 0; k < 4 && !a; k++) go(1, 0, 0, 1, dst, wr, ld, s1, u1, s2, u2, a);
   endtask

   // ---------------- monitor / scoreboard ----------------
   function automatic void check(string name, logic [15:0] act, logic [15:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, want);
      end
   endfunction

   always @(negedge clk) begin : mon
      logic [EXP_W-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("ctl", {8'h00, hz.pc_wrt_en, hz.ifDecEn, hz.decExeEn, hz.exeMemEn, hz.memWbEn,
                       hz.if_dec_flush, hz.dec_exe_bubble, hz.isStalled}, {8'h00, e[51:44]});
         check("fwd_a_sel", {14'h0, hz.fwd_a_sel}, {14'h0, e[43:42]});
         check("fwd_b_sel", {14'h0, hz.fwd_b_sel}, {14'h0, e[41:40]});
         check("stall_count", hz.stall_count, e[39:24]);
         check("flush_count", hz.flush_count, e[23:8]);
         check("stall_count_sat", {8'h00, hs.stall_count}, {8'h00, e[7:0]});
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timed out");
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      bit a;
      bit r_redir, r_mw, r_v, r_wr, r_ld, r_u1, r_u2;
      int r_dst, r_s1, r_s2;
      model_reset();
      @(posedge clk);
      #1;
      go(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
      go(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
      nop(); nop();
      // ALU producer r3 followed by a src1 consumer
      issue(3, 1, 0, 0, 0, 0, 0);
      issue(7, 1, 0, 3, 1, 0, 0);
      nop(); nop();
      // load r5 followed by a src2 consumer
      issue(5, 1, 1, 0, 0, 0, 0);
      issue(8, 1, 0, 0, 0, 5, 1);
      nop(); nop();
      // load-use hazard coinciding with a redirect
      issue(5, 1, 1, 0, 0, 0, 0);
      go(1, 1, 0, 1, 8, 1, 0, 0, 0, 5, 1, a);
      nop(); nop();
      // memory freeze over a load-use hazard
      issue(9, 1, 1, 0, 0, 0, 0);
      repeat (3) go(1, 0, 1, 1, 4, 1, 0, 9, 1, 9, 1, a);
      issue(4, 1, 0, 9, 1, 9, 1);
      nop();
      // reset pulse in the middle of a stall
      issue(5, 1, 1, 0, 0, 0, 0);
      go(1, 0, 0, 1, 6, 1, 0, 5, 1, 0, 0, a);
      go(0, 0, 0, 1, 6, 1, 0, 5, 1, 0, 0, a);
      go(1, 0, 0, 1, 6, 1, 0, 5, 1, 0, 0, a);
      nop();
      // random traffic over a small register set to provoke frequent matches
      for (int i = 0; i < 2000; i++) begin
         r_redir = ($urandom_range(0, 9) == 0);
         r_mw    = ($urandom_range(0, 9) == 0);
         r_v     = ($urandom_range(0, 4) != 0);
         r_wr    = 1'($urandom_range(0, 1));
         r_ld    = ($urandom_range(0, 2) == 0);
         r_u1    = 1'($urandom_range(0, 1));
         r_u2    = 1'($urandom_range(0, 1));
         r_dst   = int'($urandom_range(0, 3));
         r_s1    = int'($urandom_range(0, 3));
         r_s2    = int'($urandom_range(0, 3));
         go(1, r_redir, r_mw, r_v, r_dst, r_wr, r_ld, r_s1, r_u1, r_s2, r_u2, a);
      end
      // back-to-back load-use pairs drive the narrow counter past saturation
      for (int i = 0; i < 300; i++) begin
         issue(5, 1, 1, 0, 0, 0, 0);
         issue(6, 1, 0, 5, 1, 5, 1);
      end
      nop(); nop();
      @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
